// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state type and frame-length helper for the UART TX serializer
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    function automatic int frame_len(input int data_w, input int parity_mode, input int stop_bits);
        return 1 + data_w + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// rtl/uart_parity_gen.sv - combinational parity bit for one data word (0 when parity is disabled)
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = PAR_EVEN
) (
    input  logic [DATA_W-1:0] i_data,
    output logic              o_parity
);

    always_comb begin
        o_parity = 1'b0;
        if (PARITY_MODE == PAR_EVEN) begin
            o_parity = ^i_data;
        end else if (PARITY_MODE == PAR_ODD) begin
            o_parity = ~(^i_data);
        end
    end

endmodule

// File: rtl/uart_tx_ser.sv
// rtl/uart_tx_ser.sv - parametrised UART transmit serializer with one-entry holding register
// Optional line-break input enabled by defining UART_TX_BREAK_EN.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = PAR_NONE,
    parameter int STOP_BITS   = 1,
    parameter int MSB_FIRST   = 0
) (
    input  logic              bd_clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
    input  logic              tx_break,
`endif
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);

    uart_state_t       r_state;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_tx_ready;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_stop_cnt;
    logic              r_tx;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_parity;
    logic              w_hold_full;
    logic              w_accept;
    logic              w_break;
    logic              w_load;
    logic              w_out_bit;
    logic [DATA_W-1:0] w_shift_nx;

`ifdef UART_TX_BREAK_EN
    assign w_break = tx_break;
`else
    assign w_break = 1'b0;
`endif

    assign w_hold_full = ~r_tx_ready;
    assign w_accept    = tx_valid && r_tx_ready;

    // A load needs tx already high in IDLE so a released break shows at least one idle bit.
    assign w_load = w_hold_full && !w_break &&
                    (((r_state == ST_IDLE) && r_tx) ||
                     ((r_state == ST_STOP) && (r_stop_cnt == STOP_LAST)));

    assign w_out_bit  = (MSB_FIRST != 0) ? r_shift[DATA_W-1] : r_shift[0];
    assign w_shift_nx = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                         : {1'b0, r_shift[DATA_W-1:1]};

    uart_parity_gen #(
        .DATA_W      (DATA_W),
        .PARITY_MODE (PARITY_MODE)
    ) u_parity (
        .i_data   (r_hold_data),
        .o_parity (w_parity)
    );

    always_ff @(posedge bd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hold_data  <= '0;
            r_tx_ready   <= 1'b1;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_load) begin
                r_tx_ready <= 1'b1;
            end else if (w_accept) begin
                r_hold_data <= tx_data;
                r_tx_ready  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_shift <= r_hold_data;
                        r_par   <= w_parity;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end else begin
                        r_tx   <= ~w_break;
                        r_busy <= 1'b0;
                    end
                end
                ST_START: begin
                    r_tx      <= w_out_bit;
                    r_shift   <= w_shift_nx;
                    r_bit_cnt <= '0;
                    r_state   <= ST_DATA;
                end
                ST_DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        if (PARITY_MODE != PAR_NONE) begin
                            r_tx    <= r_par;
                            r_state <= ST_PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= ST_STOP;
                        end
                    end else begin
                        r_tx      <= w_out_bit;
                        r_shift   <= w_shift_nx;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    r_tx       <= 1'b1;
                    r_stop_cnt <= 1'b0;
                    r_state    <= ST_STOP;
                end
                ST_STOP: begin
                    if (r_stop_cnt == STOP_LAST) begin
                        r_frame_done <= 1'b1;
                        if (w_load) begin
                            r_shift <= r_hold_data;
                            r_par   <= w_parity;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            // A pending break drives the line low right after the stop bits.
                            r_tx    <= ~w_break;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = r_tx_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
Parametrised UART transmit serializer, next generation of the fixed 8N1-style PISO.
- Configurable data width, parity mode, stop-bit count and bit order.
- Parity is computed internally; data enters through a valid/ready handshake with a one-entry holding register, so consecutive frames go out with no idle gap.
- Sits between the TX byte source (FIFO or CPU register) and the tx pad; one bd_clk cycle equals one bit time.

Parameters:
DATA_W, 8, data bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, legal 1 or 2
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB first

Ports:
bd_clk  in  1  baud clock, one bit per rising edge
rst_n  in  1  asynchronous active-low reset
tx_valid  in  1  tx_data is valid
tx_ready  out  1  holding register empty; transfer occurs on any edge with tx_valid && tx_ready
tx_data  in  DATA_W  word to send
tx  out  1  serial line, idle high
busy  out  1  shift engine is mid-frame
frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Clock and reset: one clock, bd_clk; reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values: tx=1, busy=0, tx_ready=1, frame_done=0, state=IDLE, holding register empty.
- Frame format: start(0), DATA_W data bits, parity bit if PARITY_MODE!=0, STOP_BITS stop bits (1).
  - FRAME_LEN = 1 + DATA_W + (PARITY_MODE!=0) + STOP_BITS cycles.
- Parity:
  - even: XOR of data bits.
  - odd: inverted XOR of data bits.
  - Computed from the holding register contents at load time.
- Handshake:
  - At the accept edge E, the holding register captures tx_data and tx_ready drops at E.
  - tx_ready stays low until the edge that moves the holding word into the engine; it is high again in the cycle after that edge.
  - Accept and load never coincide, because tx_ready is low whenever the holding register is full.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE: tx=1, busy=0. If the holding register is full at an edge: load the shift register, tx<=0, state->START, busy<=1, holding register cleared.
  - Latency: accept at edge E, start bit driven from edge E+1.
  - START: one cycle, then DATA.
  - DATA: DATA_W cycles. Bit index counts 0..DATA_W-1, ordered per MSB_FIRST. Then PARITY if enabled, else STOP.
  - PARITY: one cycle, then STOP.
  - STOP: STOP_BITS cycles with tx=1. On the edge ending the last stop cycle, frame_done<=1 for exactly one cycle.
    - If the holding register is full at that edge: load, tx<=0, state->START (back-to-back, no idle bit).
    - Otherwise: state->IDLE, busy<=0.
- tx_valid deasserted mid-frame has no effect on the frame in flight.
- Reset mid-frame: tx returns to 1 and busy to 0 immediately (asynchronously). The holding word and the partial frame are discarded, and no frame_done is issued.
- Bit counter width is $clog2(DATA_W+1). No wrap beyond DATA_W-1.

Optional Feature:
UART_TX_BREAK_EN
- When defined:
  - Adds input tx_break (1 bit).
  - While tx_break=1 and the engine is in IDLE, tx is held at 0 from the next edge and no load occurs.
  - The holding register may still accept one word.
  - tx_break asserted mid-frame takes effect only after that frame's stop bits.
  - On release, tx=1 for at least one full cycle before any start bit is driven.
- When not defined: no port; the engine behaves exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the state enum typedef;
  - function frame_len(DATA_W, PARITY_MODE, STOP_BITS).
- One combinational sub-module, uart_parity_gen (DATA_W, PARITY_MODE), producing the parity bit.

Test Plan:
- Parity and bit order: DATA_W=8, even parity, send 0xA5.
  - Required tx from E+1: 0,1,0,1,0,0,1,0,1, parity 0, stop 1.
  - busy high 11 cycles; frame_done pulses once.
- Parity modes on 0x07: odd parity gives parity bit 0; even gives 1. Repeat with 0x00: odd gives 1, even gives 0.
- Back-to-back: 0x55 then 0xAA with tx_valid held high.
  - tx_ready low until the first load, then accepts 0xAA.
  - Second start bit immediately follows the first stop bit; busy high 22 contiguous cycles; two frame_done pulses 11 cycles apart.
- Narrow frame: DATA_W=7, PARITY_MODE=0, STOP_BITS=2, MSB_FIRST=1, send 0x41.
  - tx = 0,1,0,0,0,0,0,1,1,1; frame is 10 cycles.
- Reset mid-frame: assert rst_n low during data bit 3 with a word pending.
  - tx=1, busy=0, tx_ready=1 asynchronously.
  - After release, no residual frame is sent.
- Break (UART_TX_BREAK_EN): raise tx_break during a frame of 0xFF.
  - The frame completes, then tx is 0 for the break duration.
  - After release, tx is 1 for at least 1 cycle before the pending word's start bit.
